// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with a two-entry skid
// buffer, registered back-pressure, flush-to-bubble and a stall counter.
//
// Ports:
//   clk        clock; all state changes on the falling edge
//   rst        synchronous active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can take a beat (registered, no comb path)
//   in_ctrl    upstream control bits (0 = NOP)
//   in_data    upstream payload
//   out_valid  downstream beat present
//   out_ready  downstream accepts the beat
//   out_ctrl   head control bits, forced to 0 when out_valid=0
//   out_data   head payload
//   flush      turn every held entry into a bubble
//   occupancy  entries held (0..2)
//   stall_cnt  saturating count of stalled cycles
module pipe_stage_buf #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 8,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } ent_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ent_t main_q;
    ent_t skid_q;
    ent_t main_d;
    ent_t skid_d;
    ent_t in_ent;

    logic in_fire;
    logic out_fire;
    logic stall;

    // Bubble: no valid, NOP ctrl; payload optionally kept stale.
    function automatic ent_t bubble(input ent_t e);
        ent_t b;
        b.vld  = 1'b0;
        b.ctrl = '0;
        b.data = (CLEAR_DATA != 0) ? '0 : e.data;
        return b;
    endfunction

    // The skid entry is only ever filled while main is valid, so the
    // occupancy count doubles as the state encoding.
    assign occupancy = {1'b0, main_q.vld} + {1'b0, skid_q.vld};

    assign in_ready  = ~skid_q.vld;
    assign out_valid = main_q.vld;
    assign out_ctrl  = main_q.vld ? main_q.ctrl : '0;
    assign out_data  = main_q.data;

    assign in_fire  = in_valid & ~skid_q.vld;
    assign out_fire = main_q.vld & out_ready;
    assign stall    = main_q.vld & ~out_ready & ~flush;

    always_comb begin
        in_ent.vld  = 1'b1;
        in_ent.ctrl = in_ctrl;
        in_ent.data = in_data;
        main_d = main_q;
        skid_d = skid_q;
        case (occupancy)
            EMPTY: begin
                if (in_fire) begin
                    main_d = in_ent;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_ent;
                end else if (out_fire) begin
                    main_d.vld = 1'b0;
                end else if (in_fire) begin
                    skid_d = in_ent;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d     = skid_q;
                    skid_d.vld = 1'b0;
                end
            end
            default: begin
                main_d.vld = 1'b0;
                skid_d.vld = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst || flush) begin
            main_q <= bubble(main_q);
            skid_q <= bubble(skid_q);
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf.
// Main instance is model-checked; two extra instances cover params.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic        flush;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        nc_rst;
    logic        nc_in_valid;
    logic        nc_in_ready;
    logic [7:0]  nc_in_ctrl;
    logic [31:0] nc_in_data;
    logic        nc_out_valid;
    logic        nc_out_ready;
    logic [7:0]  nc_out_ctrl;
    logic [31:0] nc_out_data;
    logic        nc_flush;
    logic [1:0]  nc_occ;
    logic [15:0] nc_stall;

    logic        sat_rst;
    logic        sat_in_valid;
    logic        sat_in_ready;
    logic [7:0]  sat_in_ctrl;
    logic [31:0] sat_in_data;
    logic        sat_out_valid;
    logic        sat_out_ready;
    logic [7:0]  sat_out_ctrl;
    logic [31:0] sat_out_data;
    logic        sat_flush;
    logic [1:0]  sat_occ;
    logic [2:0]  sat_stall;

    pipe_stage_buf u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.CLEAR_DATA(0)) u_nc (
        .clk(clk), .rst(nc_rst),
        .in_valid(nc_in_valid), .in_ready(nc_in_ready),
        .in_ctrl(nc_in_ctrl), .in_data(nc_in_data),
        .out_valid(nc_out_valid), .out_ready(nc_out_ready),
        .out_ctrl(nc_out_ctrl), .out_data(nc_out_data),
        .flush(nc_flush), .occupancy(nc_occ),
        .stall_cnt(nc_stall)
    );

    pipe_stage_buf #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(sat_rst),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .in_ctrl(sat_in_ctrl), .in_data(sat_in_data),
        .out_valid(sat_out_valid), .out_ready(sat_out_ready),
        .out_ctrl(sat_out_ctrl), .out_data(sat_out_data),
        .flush(sat_flush), .occupancy(sat_occ),
        .stall_cnt(sat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit go     = 1'b0;

    logic [39:0] q[$];
    int          exp_occ   = 0;
    logic [15:0] exp_stall = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Monitor: pops the expected head on every output handshake.
    initial begin
        logic [39:0] e;
        wait (go);
        forever begin
            @(posedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_beat: got %0h want none",
                             {out_ctrl, out_data});
                end else begin
                    e = q.pop_front();
                    chk("beat", {24'd0, out_ctrl, out_data}, {24'd0, e});
                end
            end else if (!out_valid) begin
                chk("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
            end
        end
    end

    // One cycle on the main instance; updates the reference model.
    task automatic step(input logic iv, input logic [7:0] c,
                        input logic [31:0] d, input logic ordy,
                        input logic fl, input logic rs);
        bit ifire;
        bit ofire;
        @(posedge clk);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        chk("occupancy", {62'd0, occupancy}, exp_occ);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_occ < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_occ > 0});
        chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
        #2;
        ifire = iv && (exp_occ < 2);
        ofire = ordy && (exp_occ > 0);
        if (rs) begin
            q.delete();
            exp_occ   = 0;
            exp_stall = '0;
        end else begin
            if (exp_occ > 0 && !ordy && !fl && exp_stall != 16'hffff)
                exp_stall = exp_stall + 16'd1;
            if (fl) begin
                q.delete();
                exp_occ = 0;
            end else begin
                if (ifire) q.push_back({c, d});
                exp_occ = exp_occ + int'(ifire) - int'(ofire);
            end
        end
    endtask

    task automatic after_edge();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_ctrl = 0; in_data = 0;
        out_ready = 0; flush = 0;
        nc_rst = 1; nc_in_valid = 0; nc_in_ctrl = 0; nc_in_data = 0;
        nc_out_ready = 0; nc_flush = 0;
        sat_rst = 1; sat_in_valid = 0; sat_in_ctrl = 0;
        sat_in_data = 0; sat_out_ready = 0; sat_flush = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_occ", {62'd0, occupancy}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        rst = 1'b0;
        go  = 1'b1;

        // Streaming, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(i + 1), 32'h100 + i, 1, 0, 0);
            if (i == 0) begin
                after_edge();
                chk("lat1_ctrl", {56'd0, out_ctrl}, 64'd1);
                chk("lat1_data", {32'd0, out_data}, 64'h100);
            end
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Back-pressure with A,B,C.
        step(0, 0, 0, 0, 0, 1);
        step(1, 8'hA1, 32'hA, 0, 0, 0);
        step(1, 8'hB2, 32'hB, 0, 0, 0);
        step(1, 8'hC3, 32'hC, 0, 0, 0);
        step(1, 8'hC3, 32'hC, 0, 0, 0);
        after_edge();
        chk("bp_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_head", {56'd0, out_ctrl}, 64'hA1);
        chk("bp_stall", {48'd0, stall_cnt}, 64'd3);
        step(1, 8'hC3, 32'hC, 1, 0, 0);
        step(1, 8'hC3, 32'hC, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Flush while full; D must never appear.
        step(0, 0, 0, 0, 0, 1);
        step(1, 8'h11, 32'h1111, 0, 0, 0);
        step(1, 8'h22, 32'h2222, 0, 0, 0);
        step(1, 8'hDD, 32'hDDDD, 0, 1, 0);
        after_edge();
        chk("fl_occ", {62'd0, occupancy}, 64'd0);
        chk("fl_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("fl_data", {32'd0, out_data}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_stall", {48'd0, stall_cnt}, 64'd1);
        repeat (3) step(0, 0, 0, 1, 0, 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), $urandom,
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 5), 0);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // CLEAR_DATA=0 keeps stale payload across a flush.
        @(posedge clk);
        nc_rst = 0; nc_in_valid = 1; nc_in_ctrl = 8'h05;
        nc_in_data = 32'hABCD;
        after_edge();
        chk("nc_head", {56'd0, nc_out_ctrl}, 64'h05);
        @(posedge clk);
        nc_in_valid = 0; nc_flush = 1;
        after_edge();
        chk("nc_data", {32'd0, nc_out_data}, 64'hABCD);
        chk("nc_valid", {63'd0, nc_out_valid}, 64'd0);
        chk("nc_ctrl", {56'd0, nc_out_ctrl}, 64'd0);
        chk("nc_occ", {62'd0, nc_occ}, 64'd0);
        @(posedge clk);
        nc_flush = 0;

        // CNT_W=3 saturation.
        @(posedge clk);
        sat_rst = 0; sat_in_valid = 1; sat_in_ctrl = 8'h3;
        sat_in_data = 32'h33;
        @(posedge clk);
        sat_in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            after_edge();
            if (i == 6) chk("sat_at7", {61'd0, sat_stall}, 64'd7);
        end
        chk("sat_hold7", {61'd0, sat_stall}, 64'd7);
        chk("sat_occ1", {62'd0, sat_occ}, 64'd1);
        @(posedge clk);
        sat_rst = 1;
        after_edge();
        chk("sat_rst_cnt", {61'd0, sat_stall}, 64'd0);
        chk("sat_rst_occ", {62'd0, sat_occ}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer, flush-to-bubble, and a saturating stall counter. It replaces the fixed-field inter-stage latches between IF/ID/EX/MEM/WB. Any stage can now back-pressure its predecessor without a combinational ready path. A flush turns every held entry into a bubble whose control bits are all zero (NOP: no register write, no memory write).

## Interface
Parameters:
- DATA_W, 32, width of payload bus (operands, immediates, register numbers packed by the instantiating stage)
- CTRL_W, 8, width of control bus; a value of zero means NOP
- CLEAR_DATA, 1, 1: flush/reset also zero the payload registers; 0: payload registers keep stale values
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the existing pipeline registers
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts the beat this cycle
- out_ctrl  out  CTRL_W  control bits; forced to 0 whenever out_valid=0
- out_data  out  DATA_W  payload of the head entry
- flush  in  1  kill all held entries (hazard or branch squash)
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main entry (drives out_*) and skid entry, each holding a valid bit plus ctrl and data.
- States (by occupancy):
  - EMPTY (0): in_valid → load main → ONE.
  - ONE (1):
    - in and out handshake in the same cycle → main←in, stay ONE.
    - out only → EMPTY.
    - in only → skid←in → FULL.
    - neither → hold.
  - FULL (2): in_ready=0.
    - out_ready → main←skid, skid invalid → ONE.
    - otherwise hold.
- in_ready = !skid_valid. It is driven only by a register, with no combinational path from out_ready or in_valid.
- out_valid = main_valid. out_ctrl = main_valid ? main_ctrl : 0.
- Order is strictly FIFO. No beat is duplicated or dropped except by flush.
- Priority at each edge: rst > flush > normal operation.
- Flush:
  - Both valids cleared. Both ctrl registers zeroed. Data registers zeroed if CLEAR_DATA=1.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle is still consumed by downstream. The downstream stage is responsible for squashing it.
- stall_cnt:
  - +1 at each edge where out_valid=1, out_ready=0 and flush=0.
  - Saturates at 2^CNT_W−1, no wrap.
  - Cleared only by rst; flush does not clear it.
- Any CTRL_W/DATA_W ≥ 1 is legal. No arithmetic is performed on the payload.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0 (stale only if CLEAR_DATA=0), in_ready=1, occupancy=0, stall_cnt=0.
- Latency: a beat accepted at falling edge N is on out_* immediately after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Back-pressure: one cycle after out_ready falls with main valid, at most one more beat is absorbed into skid. in_ready then drops at the following edge.
- Flush recovery: in_ready=1 and out_valid=0 immediately after the flush edge. A new beat can be accepted at the very next edge.
- rst asserted mid-transfer (any state) returns to EMPTY at that edge. Held beats are lost.
- Simultaneous flush and rst: rst result (stall_cnt also cleared).

## Test plan
- Streaming: out_ready=1, 8 beats ctrl=1..8, data=0x100..0x107 back-to-back → the same sequence appears on out, one cycle later each, occupancy ≤1, stall_cnt=0.
- Back-pressure:
  - Stimulus: beats A,B,C offered; out_ready=0 for 3 cycles.
  - Required: A on out, B in skid, in_ready=0, C held upstream, stall_cnt=3.
  - After out_ready=1: A,B,C emerge in order with no loss.
- Flush while FULL: occupancy=2, flush=1 with in_valid=1 (beat D) → next cycle occupancy=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1), in_ready=1, D never appears.
- Flush with CLEAR_DATA=0: out_data keeps its prior value, out_valid=0, out_ctrl=0.
- Saturation: CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles → stall_cnt reaches 7 and stays at 7. Then rst → stall_cnt=0, occupancy=0.
- Random: random in_valid/out_ready/flush (5% flush) for 10k cycles versus a reference queue model → order preserved, no drops outside flush, occupancy never exceeds 2.
